// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL-lock driven reset sequencer: FSM encoding,
// default qualification/gap lengths and a counter sizing helper.
package pll_rst_pkg;

  localparam int LOCK_STABLE_CYC_DEF = 1024;
  localparam int STAGE_GAP_CYC_DEF   = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Parameterised flop chain for bringing asynchronous level signals into the
// clk domain; every stage resets to 0.
module sync_ff_chain #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_rst_seq.sv
// Qualifies the synchronised PLL lock, then releases NUM_STAGES reset domains
// one gap apart and raises ready; any lock loss re-asserts every domain reset.
module pll_lock_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_STABLE_CYC = LOCK_STABLE_CYC_DEF,
  parameter int STAGE_GAP_CYC   = STAGE_GAP_CYC_DEF,
  parameter int NUM_STAGES      = 3,
  parameter int CNT_W           = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic                  lock_lost_pulse,
  output logic [CNT_W-1:0]      lock_loss_cnt
);

  localparam int LW = cnt_width(LOCK_STABLE_CYC);
  localparam int GW = cnt_width(STAGE_GAP_CYC);
  localparam int SW = cnt_width(NUM_STAGES + 1);

  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_STABLE_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP_CYC - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES);

  logic          lock_s;
  state_t        state;
  logic [LW-1:0] qual_cnt;
  logic [GW-1:0] gap_cnt;
  logic [SW-1:0] stage;
  logic          lock_lost;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Only a lock drop after release has started is a counted loss.
  assign lock_lost = !lock_s && ((state == ST_RELEASE) || (state == ST_RUN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_HOLD;
      qual_cnt        <= '0;
      gap_cnt         <= '0;
      stage           <= '0;
      rst_out         <= '1;
      ready           <= 1'b0;
      lock_lost_pulse <= 1'b0;
      lock_loss_cnt   <= '0;
    end else begin
      lock_lost_pulse <= 1'b0;
      if (lock_lost) begin
        state           <= ST_HOLD;
        rst_out         <= '1;
        ready           <= 1'b0;
        lock_lost_pulse <= 1'b1;
        if (lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
      end else if (soft_rst_req) begin
        state   <= ST_HOLD;
        rst_out <= '1;
        ready   <= 1'b0;
      end else begin
        case (state)
          ST_HOLD: begin
            rst_out <= '1;
            ready   <= 1'b0;
            if (lock_s) begin
              state    <= ST_WAIT;
              qual_cnt <= '0;
            end
          end
          ST_WAIT: begin
            if (!lock_s) begin
              state <= ST_HOLD;
            end else if (qual_cnt == LOCK_LAST) begin
              state      <= ST_RELEASE;
              rst_out[0] <= 1'b0;
              stage      <= SW'(1);
              gap_cnt    <= '0;
            end else begin
              qual_cnt <= qual_cnt + LW'(1);
            end
          end
          ST_RELEASE: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              if (stage == STAGE_LAST) begin
                state <= ST_RUN;
                ready <= 1'b1;
              end else begin
                // Masking keeps already-released bits low, so order is preserved.
                rst_out <= rst_out & ~(NUM_STAGES'(1) << stage);
                stage   <= stage + SW'(1);
              end
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          ST_RUN: begin
            rst_out <= '0;
            ready   <= 1'b1;
          end
          default: state <= ST_HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed bench for pll_lock_rst_seq: the driver pushes every expected output
// change (cycle stamp + value) and a negedge monitor pops and compares them.
module tb_pll_lock_rst_seq;

  localparam int EW = 23;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       soft_rst_req;
  logic [2:0] rst_out;
  logic       ready;
  logic       lock_lost_pulse;
  logic [1:0] lock_loss_cnt;

  int cyc;
  int checks;
  int errors;

  logic [EW-1:0] exp_q[$];

  pll_lock_rst_seq #(
    .SYNC_STAGES     (2),
    .LOCK_STABLE_CYC (8),
    .STAGE_GAP_CYC   (4),
    .NUM_STAGES      (3),
    .CNT_W           (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_lock        (pll_lock),
    .soft_rst_req    (soft_rst_req),
    .rst_out         (rst_out),
    .ready           (ready),
    .lock_lost_pulse (lock_lost_pulse),
    .lock_loss_cnt   (lock_loss_cnt)
  );

  // Clock and edge counter: cyc holds the number of rising edges so far.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver helpers: every expected entry is {edge number, rst_out, ready, pulse, cnt}.
  task automatic push_exp(input int n, input logic [2:0] r, input logic rd,
                          input logic p, input logic [1:0] c);
    exp_q.push_back({16'(n), r, rd, p, c});
  endtask

  task automatic push_release(input int b, input logic [1:0] c);
    push_exp(b + 10, 3'b110, 1'b0, 1'b0, c);
    push_exp(b + 14, 3'b100, 1'b0, 1'b0, c);
    push_exp(b + 18, 3'b000, 1'b0, 1'b0, c);
    push_exp(b + 22, 3'b000, 1'b1, 1'b0, c);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: any change of the output tuple must match the next expected entry.
  logic [6:0]    obs;
  logic [6:0]    last_obs;
  logic          seen;
  logic [EW-1:0] act;
  logic [EW-1:0] exp_v;

  initial seen = 1'b0;

  always @(negedge clk) begin
    obs = {rst_out, ready, lock_lost_pulse, lock_loss_cnt};
    if (!seen || obs !== last_obs) begin
      seen     = 1'b1;
      last_obs = obs;
      act      = {16'(cyc), obs};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: edge %0d got rst_out/ready/pulse/cnt=%b, none expected",
                 cyc, obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          errors++;
          $display("FAIL out_change: got edge %0d value %b, expected edge %0d value %b",
                   cyc, obs, exp_v[EW-1:7], exp_v[6:0]);
        end
      end
    end
  end

  // Stimulus
  int         base;
  int         e;
  int         s;
  logic [1:0] c;

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    pll_lock     = 1'b0;
    soft_rst_req = 1'b0;
    push_exp(1, 3'b111, 1'b0, 1'b0, 2'd0);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);

    // Clean start: lock high from edge base.
    rst      = 1'b0;
    pll_lock = 1'b1;
    base     = cyc + 1;
    push_release(base, 2'd0);
    wait_until(base + 26);

    // Loss in RUN, then re-lock.
    pll_lock = 1'b0;
    e        = cyc + 1;
    push_exp(e + 2, 3'b111, 1'b0, 1'b1, 2'd1);
    push_exp(e + 3, 3'b111, 1'b0, 1'b0, 2'd1);
    wait_until(e + 5);
    pll_lock = 1'b1;
    base     = cyc + 1;
    push_release(base, 2'd1);
    wait_until(base + 26);

    // One-cycle soft reset request in RUN: HOLD, no pulse, count unchanged.
    soft_rst_req = 1'b1;
    s            = cyc + 1;
    push_exp(s, 3'b111, 1'b0, 1'b0, 2'd1);
    push_release(s - 1, 2'd1);
    @(negedge clk);
    soft_rst_req = 1'b0;
    wait_until(s + 26);

    // Another loss, re-lock, then async reset while rst_out == 100.
    pll_lock = 1'b0;
    e        = cyc + 1;
    push_exp(e + 2, 3'b111, 1'b0, 1'b1, 2'd2);
    push_exp(e + 3, 3'b111, 1'b0, 1'b0, 2'd2);
    wait_until(e + 5);
    pll_lock = 1'b1;
    base     = cyc + 1;
    push_exp(base + 10, 3'b110, 1'b0, 1'b0, 2'd2);
    push_exp(base + 14, 3'b100, 1'b0, 1'b0, 2'd2);
    wait_until(base + 15);
    push_exp(base + 16, 3'b111, 1'b0, 1'b0, 2'd0);
    #2;
    rst      = 1'b1;
    pll_lock = 1'b0;
    #1;
    checks++;
    if ({rst_out, ready, lock_lost_pulse, lock_loss_cnt} !== 7'b111_0_0_00) begin
      errors++;
      $display("FAIL async_rst: got %b, expected 1110000 before any clk edge",
               {rst_out, ready, lock_lost_pulse, lock_loss_cnt});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Glitch in WAIT: low for edges base+5..base+7, re-qualify from base+8.
    pll_lock = 1'b1;
    base     = cyc + 1;
    push_release(base + 8, 2'd0);
    wait_until(base + 4);
    pll_lock = 1'b0;
    wait_until(base + 7);
    pll_lock = 1'b1;
    wait_until(base + 34);

    // Five losses from RUN: count saturates at 3, pulse every time.
    c = 2'd0;
    for (int i = 0; i < 5; i++) begin
      if (c != 2'd3) c = c + 2'd1;
      pll_lock = 1'b0;
      e        = cyc + 1;
      push_exp(e + 2, 3'b111, 1'b0, 1'b1, c);
      push_exp(e + 3, 3'b111, 1'b0, 1'b0, c);
      wait_until(e + 5);
      pll_lock = 1'b1;
      base     = cyc + 1;
      push_release(base, c);
      wait_until(base + 26);
    end

    repeat (4) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_change: expected edge %0d value %b never observed",
               exp_v[EW-1:7], exp_v[6:0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
